uart_rx: RTL and testbench

//  UART receiver: 8N1, LSB first, idle-high line. Mirrors the existing transmitter on the same link.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   UART_CLKS_PER_BIT : clocks per bit, 50 MHz / 115200 baud.
//   UART_DATA_W       : data bits per frame.
//   uart_rx_state_t   : receiver FSM state encoding.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side receive FIFO port of the UART receiver.
//   RxFifoRead   : pop request from the consumer.
//   RxData       : show-ahead FIFO head byte.
//   RxFifoEmpty  : FIFO empty.
//   RxFifoFull   : FIFO full (DEPTH-1 entries held).
//   RxFrameError : one-cycle pulse, stop bit sampled low.
//   RxOverrun    : one-cycle pulse, good byte dropped because FIFO full.
// slave modport is used by uart_rx, master by the consuming logic.
interface uart_rx_if
    import uart_pkg::*;
;
    logic                   RxFifoRead;
    logic [UART_DATA_W-1:0] RxData;
    logic                   RxFifoEmpty;
    logic                   RxFifoFull;
    logic                   RxFrameError;
    logic                   RxOverrun;

    modport slave (
        input  RxFifoRead,
        output RxData,
        output RxFifoEmpty,
        output RxFifoFull,
        output RxFrameError,
        output RxOverrun
    );

    modport master (
        output RxFifoRead,
        input  RxData,
        input  RxFifoEmpty,
        input  RxFifoFull,
        input  RxFrameError,
        input  RxOverrun
    );

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: pointer-based synchronous FIFO with show-ahead read.
//   clock, nReset : clock, asynchronous active-low reset (pointers only).
//   wr, wdata     : write request and data; ignored when full.
//   rd            : pop request; ignored when empty.
//   rdata         : head entry, forced to 0 while empty.
//   empty, full   : derived from the current pointers; capacity DEPTH-1.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtrInc;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wrEn;
    logic              rdEn;

    // Pointer arithmetic wraps naturally at the power-of-two depth.
    assign wrPtrInc = wrPtr + 1'b1;
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtrInc == rdPtr);
    assign wrEn     = wr && !full;
    assign rdEn     = rd && !empty;
    assign rdata    = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtrInc;
            if (rdEn) rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wrEn) mem[wrPtr] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line, with receive FIFO.
//   clock  : system clock.
//   nReset : asynchronous active-low reset.
//   Rx     : asynchronous serial input.
//   rxIf   : FIFO read port and error pulses (uart_rx_if.slave).
// Every bit is sampled at its centre using a counter clocked from the
// detected start edge; good bytes are written on the stop-sample edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 1024
) (
    input  logic     clock,
    input  logic     nReset,
    input  logic     Rx,
    uart_rx_if.slave rxIf
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic                   rxMeta;
    logic                   rxSync;
    uart_rx_state_t         state;
    uart_rx_state_t         nextState;
    logic [CNT_W-1:0]       bitCnt;
    logic [CNT_W-1:0]       bitCntNext;
    logic [2:0]             dataCnt;
    logic [2:0]             dataCntNext;
    logic [UART_DATA_W-1:0] shiftReg;
    logic [UART_DATA_W-1:0] shiftNext;
    logic                   armed;
    logic                   armedNext;
    logic                   fifoWr;
    logic                   frameErr;
    logic                   frameErrNext;
    logic                   overrun;
    logic                   overrunNext;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= Rx;
            rxSync <= rxMeta;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            dataCnt  <= '0;
            armed    <= 1'b1;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= nextState;
            bitCnt   <= bitCntNext;
            dataCnt  <= dataCntNext;
            armed    <= armedNext;
            frameErr <= frameErrNext;
            overrun  <= overrunNext;
        end
    end

    always_ff @(posedge clock) begin
        shiftReg <= shiftNext;
    end

    always_comb begin
        nextState    = state;
        bitCntNext   = bitCnt + 1'b1;
        dataCntNext  = dataCnt;
        shiftNext    = shiftReg;
        armedNext    = armed;
        fifoWr       = 1'b0;
        frameErrNext = 1'b0;
        overrunNext  = 1'b0;
        case (state)
            IDLE: begin
                // After a frame error the line must be seen high for a
                // whole bit before a new start edge is trusted (break).
                if (!armed) begin
                    if (!rxSync) begin
                        bitCntNext = '0;
                    end else if (bitCnt == LAST_CNT) begin
                        armedNext  = 1'b1;
                        bitCntNext = '0;
                    end
                end else begin
                    bitCntNext = '0;
                    if (!rxSync) nextState = START;
                end
            end
            START: begin
                if (bitCnt == HALF_CNT) begin
                    bitCntNext  = '0;
                    dataCntNext = '0;
                    // Line back high at mid-start: a glitch, silently ignored.
                    nextState   = rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bitCnt == LAST_CNT) begin
                    bitCntNext         = '0;
                    shiftNext[dataCnt] = rxSync;
                    dataCntNext        = dataCnt + 3'd1;
                    if (dataCnt == 3'd7) nextState = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught.
                if (bitCnt == LAST_CNT) begin
                    bitCntNext = '0;
                    nextState  = IDLE;
                    if (!rxSync) begin
                        frameErrNext = 1'b1;
                        armedNext    = 1'b0;
                    end else if (rxIf.RxFifoFull) begin
                        overrunNext = 1'b1;
                    end else begin
                        fifoWr = 1'b1;
                    end
                end
            end
            default: begin
                nextState  = IDLE;
                bitCntNext = '0;
            end
        endcase
    end

    assign rxIf.RxFrameError = frameErr;
    assign rxIf.RxOverrun    = overrun;

    uart_fifo #(
        .DATA_W (UART_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) rxFifo (
        .clock  (clock),
        .nReset (nReset),
        .wr     (fifoWr),
        .wdata  (shiftReg),
        .rd     (rxIf.RxFifoRead),
        .rdata  (rxIf.RxData),
        .empty  (rxIf.RxFifoEmpty),
        .full   (rxIf.RxFifoFull)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (434 clocks/bit, 4-entry FIFO).
// Stimulus pushes expected bytes and expected error pulses; a monitor pops
// the FIFO whenever reading is enabled and checks against the scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 434;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic nReset;
    logic Rx;

    uart_rx_if rxIf ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock  (clock),
        .nReset (nReset),
        .Rx     (Rx),
        .rxIf   (rxIf)
    );

    always #10 clock = ~clock;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] expQ[$];
    int         expFrameErr = 0;
    int         expOverrun  = 0;
    bit         readEn      = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Callers are aligned to a negedge; each bit lasts CPB clocks.
    task automatic sendBit(input logic b);
        Rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stopBit);
    endtask

    task automatic idleBits(input int n);
        Rx = 1'b1;
        repeat (n * CPB) @(negedge clock);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && (expQ.size() != 0 || expFrameErr != 0 || expOverrun != 0); i++)
            @(negedge clock);
        repeat (4) @(negedge clock);
        check({name, "_pending_bytes"}, expQ.size(), 0);
        check({name, "_pending_frame_err"}, expFrameErr, 0);
        check({name, "_pending_overrun"}, expOverrun, 0);
        check({name, "_empty"}, rxIf.RxFifoEmpty, 1);
    endtask

    // Monitor: checks error pulses and pops the FIFO one entry per two cycles.
    initial begin
        rxIf.RxFifoRead = 1'b0;
        forever begin
            @(negedge clock);
            if (nReset === 1'b1 && rxIf.RxFrameError === 1'b1) begin
                vectors++;
                if (expFrameErr > 0) expFrameErr--;
                else begin
                    miscompares++;
                    $display("FAIL frame_error: got unexpected pulse, expected none");
                end
            end
            if (nReset === 1'b1 && rxIf.RxOverrun === 1'b1) begin
                vectors++;
                if (expOverrun > 0) expOverrun--;
                else begin
                    miscompares++;
                    $display("FAIL overrun: got unexpected pulse, expected none");
                end
            end
            if (rxIf.RxFifoRead) begin
                rxIf.RxFifoRead = 1'b0;
            end else if (readEn && nReset === 1'b1 && rxIf.RxFifoEmpty === 1'b0) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_data: got unexpected byte 0x%0h, expected none", rxIf.RxData);
                end else begin
                    check("rx_data", rxIf.RxData, expQ.pop_front());
                end
                rxIf.RxFifoRead = 1'b1;
            end
        end
    end

    initial begin
        #1700000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0;
        Rx     = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_empty", rxIf.RxFifoEmpty, 1);
        check("reset_full", rxIf.RxFifoFull, 0);
        check("reset_frame_err", rxIf.RxFrameError, 0);
        check("reset_overrun", rxIf.RxOverrun, 0);
        check("reset_data", rxIf.RxData, 0);
        nReset = 1'b1;
        idleBits(1);

        // 1: single byte with write timing at mid-stop
        expQ.push_back(8'hA5);
        @(negedge clock);
        fork
            sendFrame(8'hA5, 1'b1);
            begin
                repeat (4125) @(posedge clock);
                #1 check("t1_empty_before_stop_sample", rxIf.RxFifoEmpty, 1);
                @(posedge clock);
                #1 check("t1_empty_after_stop_sample", rxIf.RxFifoEmpty, 0);
                check("t1_head_after_stop_sample", rxIf.RxData, 8'hA5);
            end
        join
        check("t1_still_held", rxIf.RxFifoEmpty, 0);
        readEn = 1'b1;
        drain("t1");

        // 2: 100-clock low glitch
        Rx = 1'b0;
        repeat (100) @(negedge clock);
        idleBits(2);
        check("t2_state_idle", dut.state, IDLE);
        drain("t2");

        // 3: framing error then a good frame
        expFrameErr++;
        sendFrame(8'h3C, 1'b0);
        check("t3_empty_after_frame_err", rxIf.RxFifoEmpty, 1);
        idleBits(2);
        expQ.push_back(8'h55);
        sendFrame(8'h55, 1'b1);
        idleBits(1);
        drain("t3");

        // 4: back-to-back frames with single stop bits
        expQ.push_back(8'h01);
        expQ.push_back(8'h80);
        expQ.push_back(8'hFF);
        sendFrame(8'h01, 1'b1);
        sendFrame(8'h80, 1'b1);
        sendFrame(8'hFF, 1'b1);
        idleBits(1);
        drain("t4");

        // 5: fill the 4-entry FIFO, fourth byte overruns
        readEn = 1'b0;
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        expQ.push_back(8'h33);
        sendFrame(8'h11, 1'b1);
        sendFrame(8'h22, 1'b1);
        check("t5_full_after_2", rxIf.RxFifoFull, 0);
        sendFrame(8'h33, 1'b1);
        check("t5_full_after_3", rxIf.RxFifoFull, 1);
        expOverrun++;
        sendFrame(8'h44, 1'b1);
        idleBits(1);
        check("t5_full_after_overrun", rxIf.RxFifoFull, 1);
        check("t5_head_after_overrun", rxIf.RxData, 8'h11);
        readEn = 1'b1;
        drain("t5");
        check("t5_full_after_drain", rxIf.RxFifoFull, 0);

        // 6: reset during data bit 4 clears FIFO and partial frame
        readEn = 1'b0;
        sendFrame(8'h96, 1'b1);
        idleBits(1);
        check("t6_byte_before_reset", rxIf.RxFifoEmpty, 0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        Rx = 1'b1;
        repeat (200) @(negedge clock);
        nReset = 1'b0;
        #1;
        check("t6_reset_empty", rxIf.RxFifoEmpty, 1);
        check("t6_reset_full", rxIf.RxFifoFull, 0);
        check("t6_reset_frame_err", rxIf.RxFrameError, 0);
        check("t6_reset_overrun", rxIf.RxOverrun, 0);
        check("t6_reset_data", rxIf.RxData, 0);
        check("t6_reset_state", dut.state, IDLE);
        repeat (5) @(negedge clock);
        nReset = 1'b1;
        idleBits(2);
        expQ.push_back(8'hC3);
        readEn = 1'b1;
        sendFrame(8'hC3, 1'b1);
        idleBits(1);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
